// File: rtl/aes_key_ctrl.sv
// aes_key_ctrl: key load, expansion handshake, watchdog and S-box arbitration between key memory and cipher
module aes_key_ctrl #(
   parameter int WDOG_MAX = 31
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [255:0] cfg_key,
   input  logic         cfg_keylen,
   output logic [255:0] km_key,
   output logic         km_keylen,
   output logic         km_init,
   input  logic         km_ready,
   input  logic         blk_req,
   output logic         blk_gnt,
   input  logic         blk_done,
   output logic         sbox_sel,
   output logic         key_valid,
   output logic [3:0]   num_rounds,
   output logic         err,
   output logic         busy
);
   typedef enum logic [2:0] {IDLE, LOAD, WAIT_LOW, WAIT_HIGH, READY, BLOCK, ERR} state_t;
   localparam int WW = (WDOG_MAX < 1) ? 1 : $clog2(WDOG_MAX + 1);
   state_t state, state_nx;
   logic [WW-1:0] wdog;
   logic xfer, wdog_max, waiting;
   assign cfg_ready  = (state == IDLE) || (state == READY) || (state == ERR);
   assign xfer       = cfg_valid && cfg_ready;
   assign wdog_max   = wdog == WW'(WDOG_MAX);
   assign waiting    = (state == WAIT_LOW) || (state == WAIT_HIGH);
   assign km_init    = state == LOAD;
   assign sbox_sel   = state == BLOCK;
   assign key_valid  = (state == READY) || (state == BLOCK);
   assign err        = state == ERR;
   assign busy       = (state == LOAD) || waiting || (state == BLOCK);
   assign num_rounds = km_keylen ? 4'd14 : 4'd10;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, ERR: state_nx = xfer ? LOAD : state;
         LOAD:      state_nx = WAIT_LOW;
         WAIT_LOW:  state_nx = wdog_max ? ERR : (!km_ready ? WAIT_HIGH : WAIT_LOW);
         WAIT_HIGH: state_nx = km_ready ? READY : (wdog_max ? ERR : WAIT_HIGH);
         READY:     state_nx = xfer ? LOAD : (blk_req ? BLOCK : READY);
         BLOCK:     state_nx = blk_done ? READY : BLOCK;
         default:   state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         wdog      <= '0;
         km_key    <= '0;
         km_keylen <= 1'b0;
         blk_gnt   <= 1'b0;
      end else begin
         state   <= state_nx;
         blk_gnt <= (state == READY) && (state_nx == BLOCK);
         if (xfer) begin
            km_key    <= cfg_key;
            km_keylen <= cfg_keylen;
            wdog      <= '0;
         end else if (waiting && !wdog_max) begin
            wdog <= wdog + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_aes_key_ctrl.sv
// tb_aes_key_ctrl: directed scenarios against a small key-memory model
module tb_aes_key_ctrl;
   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] K2   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K3   = ~K256;
   logic clk = 1'b0, reset_n = 1'b0, cfg_valid = 1'b0, cfg_keylen = 1'b0;
   logic blk_req = 1'b0, blk_done = 1'b0, km_ready = 1'b1;
   logic [255:0] cfg_key = '0;
   logic cfg_ready, km_keylen, km_init, blk_gnt, sbox_sel, key_valid, err, busy;
   logic [255:0] km_key;
   logic [3:0] num_rounds;
   int n_cmp = 0, n_bad = 0, init_cnt = 0, gnt_cnt = 0, fall_cnt = 0, mcnt = 0;
   bit model_dead = 1'b0;

   aes_key_ctrl dut (
      .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_key(cfg_key), .cfg_keylen(cfg_keylen), .km_key(km_key), .km_keylen(km_keylen),
      .km_init(km_init), .km_ready(km_ready), .blk_req(blk_req), .blk_gnt(blk_gnt),
      .blk_done(blk_done), .sbox_sel(sbox_sel), .key_valid(key_valid),
      .num_rounds(num_rounds), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   // key memory: drops ready one edge after init, raises it three edges later
   always @(posedge clk) begin
      if (km_init) begin
         km_ready <= 1'b0;
         mcnt <= 3;
      end else if (mcnt > 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1 && !model_dead) km_ready <= 1'b1;
      end
   end
   always @(posedge clk) if (km_init) init_cnt <= init_cnt + 1;
   always @(posedge clk) if (blk_gnt) gnt_cnt <= gnt_cnt + 1;
   always @(negedge km_ready) fall_cnt <= fall_cnt + 1;

   task automatic do_load(input logic [255:0] k, input logic len);
      cfg_key = k;
      cfg_keylen = len;
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic wait_kv(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (key_valid) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic wait_gnt(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (blk_gnt) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if ({km_init, blk_gnt, sbox_sel, key_valid, err, busy, cfg_ready} !== 7'b0000001) begin n_bad++; $display("FAIL reset_flags: got %b want 0000001", {km_init, blk_gnt, sbox_sel, key_valid, err, busy, cfg_ready}); end
      n_cmp++; if (num_rounds !== 4'd10) begin n_bad++; $display("FAIL reset_rounds: got %0d want 10", num_rounds); end
      n_cmp++; if ({km_key, km_keylen} !== 257'h0) begin n_bad++; $display("FAIL reset_key: got %h/%b want 0", km_key, km_keylen); end
      reset_n = 1'b1;
      @(negedge clk);
      n_cmp++; if ({cfg_ready, busy, key_valid} !== 3'b100) begin n_bad++; $display("FAIL idle_after_reset: got %b want 100", {cfg_ready, busy, key_valid}); end
   endtask

   task automatic test_aes128;
      int i0, f0;
      bit ok;
      i0 = init_cnt;
      f0 = fall_cnt;
      do_load(K128, 1'b0);
      n_cmp++; if ({km_init, busy, cfg_ready} !== 3'b110) begin n_bad++; $display("FAIL load128_state: got %b want 110", {km_init, busy, cfg_ready}); end
      n_cmp++; if ({km_key, km_keylen} !== {K128, 1'b0}) begin n_bad++; $display("FAIL load128_key: got %h/%b want %h/0", km_key, km_keylen, K128); end
      @(negedge clk);
      n_cmp++; if (km_init !== 1'b0) begin n_bad++; $display("FAIL load128_init_pulse: got %b want 0", km_init); end
      wait_kv(ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL load128_key_valid: got %b want 1", ok); end
      n_cmp++; if (init_cnt - i0 !== 1) begin n_bad++; $display("FAIL load128_init_count: got %0d want 1", init_cnt - i0); end
      n_cmp++; if (fall_cnt - f0 !== 1 || km_ready !== 1'b1) begin n_bad++; $display("FAIL load128_ready_seq: got falls %0d ready %b want 1 1", fall_cnt - f0, km_ready); end
      n_cmp++; if ({num_rounds, busy, err} !== {4'd10, 2'b00}) begin n_bad++; $display("FAIL load128_outputs: got %0d %b %b want 10 0 0", num_rounds, busy, err); end
   endtask

   task automatic test_aes256_block;
      int g0;
      bit ok;
      g0 = gnt_cnt;
      do_load(K256, 1'b1);
      blk_req = 1'b1;
      wait_gnt(ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL blk_grant_seen: got %b want 1", ok); end
      n_cmp++; if ({key_valid, sbox_sel, num_rounds} !== {2'b11, 4'd14}) begin n_bad++; $display("FAIL blk_first_cycle: got %b %b %0d want 1 1 14", key_valid, sbox_sel, num_rounds); end
      blk_req = 1'b0;
      @(negedge clk);
      n_cmp++; if ({blk_gnt, sbox_sel, busy} !== 3'b011) begin n_bad++; $display("FAIL blk_second_cycle: got %b want 011", {blk_gnt, sbox_sel, busy}); end
      @(negedge clk);
      n_cmp++; if (sbox_sel !== 1'b1) begin n_bad++; $display("FAIL blk_sbox_held: got %b want 1", sbox_sel); end
      blk_done = 1'b1;
      @(negedge clk);
      blk_done = 1'b0;
      n_cmp++; if ({sbox_sel, busy, key_valid} !== 3'b001) begin n_bad++; $display("FAIL blk_done_return: got %b want 001", {sbox_sel, busy, key_valid}); end
      n_cmp++; if (gnt_cnt - g0 !== 1) begin n_bad++; $display("FAIL blk_grant_count: got %0d want 1", gnt_cnt - g0); end
   endtask

   task automatic test_priority;
      int g0, i0;
      bit ok;
      g0 = gnt_cnt;
      i0 = init_cnt;
      cfg_key = K2;
      cfg_keylen = 1'b0;
      cfg_valid = 1'b1;
      blk_req = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      n_cmp++; if ({km_init, blk_gnt, key_valid, sbox_sel} !== 4'b1000) begin n_bad++; $display("FAIL prio_load_wins: got %b want 1000", {km_init, blk_gnt, key_valid, sbox_sel}); end
      n_cmp++; if ({km_key, num_rounds} !== {K2, 4'd10}) begin n_bad++; $display("FAIL prio_new_key: got %h %0d want %h 10", km_key, num_rounds, K2); end
      wait_gnt(ok);
      n_cmp++; if ({ok, key_valid} !== 2'b11) begin n_bad++; $display("FAIL prio_grant_after: got %b want 11", {ok, key_valid}); end
      blk_req = 1'b0;
      blk_done = 1'b1;
      @(negedge clk);
      blk_done = 1'b0;
      n_cmp++; if (gnt_cnt - g0 !== 1 || init_cnt - i0 !== 1) begin n_bad++; $display("FAIL prio_counts: got gnt %0d init %0d want 1 1", gnt_cnt - g0, init_cnt - i0); end
   endtask

   task automatic test_watchdog;
      int g0;
      bit ok;
      model_dead = 1'b1;
      do_load(K3, 1'b1);
      repeat (31) @(negedge clk);
      n_cmp++; if ({err, busy} !== 2'b01) begin n_bad++; $display("FAIL wdog_not_yet: got %b want 01", {err, busy}); end
      repeat (2) @(negedge clk);
      n_cmp++; if ({err, key_valid, busy, cfg_ready, km_init} !== 5'b10010) begin n_bad++; $display("FAIL wdog_err: got %b want 10010", {err, key_valid, busy, cfg_ready, km_init}); end
      g0 = gnt_cnt;
      blk_req = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++; if (gnt_cnt !== g0 || sbox_sel !== 1'b0 || err !== 1'b1) begin n_bad++; $display("FAIL wdog_blk_ignored: got gnt %0d sbox %b err %b want 0 0 1", gnt_cnt - g0, sbox_sel, err); end
      blk_req = 1'b0;
      model_dead = 1'b0;
      do_load(K128, 1'b0);
      n_cmp++; if ({err, km_init} !== 2'b01) begin n_bad++; $display("FAIL wdog_clear: got %b want 01", {err, km_init}); end
      wait_kv(ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wdog_recover: got %b want 1", ok); end
   endtask

   task automatic test_cfg_during_block;
      bit ok;
      blk_req = 1'b1;
      @(negedge clk);
      n_cmp++; if (blk_gnt !== 1'b1) begin n_bad++; $display("FAIL stall_grant: got %b want 1", blk_gnt); end
      blk_req = 1'b0;
      cfg_key = K3;
      cfg_keylen = 1'b1;
      cfg_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if ({cfg_ready, km_init} !== 2'b00 || km_key !== K128) begin n_bad++; $display("FAIL stall_in_block: got rdy %b init %b key %h want 0 0 %h", cfg_ready, km_init, km_key, K128); end
      end
      blk_done = 1'b1;
      @(negedge clk);
      blk_done = 1'b0;
      n_cmp++; if ({cfg_ready, key_valid, km_init} !== 3'b110) begin n_bad++; $display("FAIL stall_ready: got %b want 110", {cfg_ready, key_valid, km_init}); end
      @(negedge clk);
      cfg_valid = 1'b0;
      n_cmp++; if (km_init !== 1'b1 || km_key !== K3 || num_rounds !== 4'd14) begin n_bad++; $display("FAIL stall_accepted: got %b %h %0d want 1 %h 14", km_init, km_key, num_rounds, K3); end
      wait_kv(ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stall_expand: got %b want 1", ok); end
   endtask

   task automatic test_reset_mid;
      int g0, i0;
      bit ok;
      g0 = gnt_cnt;
      i0 = init_cnt;
      do_load(K128, 1'b0);
      blk_req = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if ({busy, key_valid, km_init} !== 3'b100) begin n_bad++; $display("FAIL mid_waiting: got %b want 100", {busy, key_valid, km_init}); end
      reset_n = 1'b0;
      #1;
      n_cmp++; if ({km_init, blk_gnt, sbox_sel, key_valid, err, busy, cfg_ready} !== 7'b0000001 || num_rounds !== 4'd10 || km_key !== '0) begin n_bad++; $display("FAIL mid_reset_vals: got %b %0d %h want 0000001 10 0", {km_init, blk_gnt, sbox_sel, key_valid, err, busy, cfg_ready}, num_rounds, km_key); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      n_cmp++; if (gnt_cnt !== g0 || init_cnt - i0 !== 1) begin n_bad++; $display("FAIL mid_no_pulses: got gnt %0d init %0d want 0 1", gnt_cnt - g0, init_cnt - i0); end
      n_cmp++; if ({key_valid, cfg_ready, busy} !== 3'b010) begin n_bad++; $display("FAIL mid_idle: got %b want 010", {key_valid, cfg_ready, busy}); end
      do_load(K256, 1'b1);
      wait_gnt(ok);
      n_cmp++; if ({ok, num_rounds} !== {1'b1, 4'd14}) begin n_bad++; $display("FAIL mid_grant_after_load: got %b %0d want 1 14", ok, num_rounds); end
      blk_req = 1'b0;
      blk_done = 1'b1;
      @(negedge clk);
      blk_done = 1'b0;
   endtask

   initial begin
      test_reset;
      test_aes128;
      test_aes256_block;
      test_priority;
      test_watchdog;
      test_cfg_during_block;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
